// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/VESA raster timing generator.
// Produces hcount/vcount, sync, blanking, data-enable and frame/line strobes.
// All outputs are registered and decoded from the next counter values, so every
// flag lines up with the hcount/vcount it is presented with.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter
// output (frame_cnt) that increments whenever a new frame starts.

module vga_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   CW       = 12
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          de,
  output logic          sof,
  output logic          eol
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter range must cover both totals, otherwise the raster cannot be counted.
  localparam longint CNT_RANGE = longint'(1) << CW;

  generate
    if (CNT_RANGE < longint'(H_TOTAL) || CNT_RANGE < longint'(V_TOTAL)) begin : g_cw_too_small
      $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end
  endgenerate

  // Decode thresholds in counter width so all comparisons are CW-bit unsigned.
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END_C   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END_C   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblnk_q, hblnk_d;
  logic          vblnk_q, vblnk_d;
  logic          de_q, de_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

  // Next-state: advance the raster on ce, decode every flag from the new position.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    hblnk_d  = hblnk_q;
    vblnk_d  = vblnk_q;
    de_d     = de_q;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif
    if (ce) begin
      if (hcount_q == H_LAST_C) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST_C) ? '0 : vcount_q + ONE_C;
      end else begin
        hcount_d = hcount_q + ONE_C;
      end
      hblnk_d = (hcount_d >= H_ACT_C);
      vblnk_d = (vcount_d >= V_ACT_C);
      hsync_d = ((hcount_d >= HS_START_C) && (hcount_d <= HS_END_C)) ? HS_POL : ~HS_POL;
      vsync_d = ((vcount_d >= VS_START_C) && (vcount_d <= VS_END_C)) ? VS_POL : ~VS_POL;
      de_d    = !hblnk_d && !vblnk_d;
      sof_d   = (hcount_d == '0) && (vcount_d == '0);
      eol_d   = (hcount_d == H_LAST_C);
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (sof_d) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
`endif
    end
  end

  // State register: reset wins over ce; syncs idle at their deasserted level.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      de_q     <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      de_q     <= de_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter register: bumps together with sof, wraps naturally at 16 bits.
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign hblnk  = hblnk_q;
  assign vblnk  = vblnk_q;
  assign de     = de_q;
  assign sof    = sof_q;
  assign eol    = eol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Three instances share clock, reset and ce: the default 1024x768 timing, and a
// tiny 16x8 raster in both sync polarities so whole frames fit in a short run.
// Small raster: H 8/2/3/3 (total 16, hblnk h>=8, hsync h 10..12),
//               V 4/1/2/1 (total 8, vblnk v>=4, vsync v 5..6), frame = 128 ce.

module tb_vga_timing_gen;

  logic pclk;
  logic rst;
  logic ce;

  int checks   = 0;
  int failures = 0;

  // Default-parameter instance.
  logic [11:0] d_h, d_v;
  logic        d_hs, d_vs, d_hb, d_vb, d_de, d_sof, d_eol;
  // Small raster, active-high syncs.
  logic [4:0]  s_h, s_v;
  logic        s_hs, s_vs, s_hb, s_vb, s_de, s_sof, s_eol;
  // Small raster, active-low syncs.
  logic [4:0]  n_h, n_v;
  logic        n_hs, n_vs, n_hb, n_vb, n_de, n_sof, n_eol;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc, n_fc;
`endif

  // Clock/reset block.
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  vga_timing_gen u_def (
    .pclk(pclk), .rst(rst), .ce(ce),
    .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .hblnk(d_hb), .vblnk(d_vb), .de(d_de), .sof(d_sof), .eol(d_eol)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)
  ) u_sm (
    .pclk(pclk), .rst(rst), .ce(ce),
    .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .hblnk(s_hb), .vblnk(s_vb), .de(s_de), .sof(s_sof), .eol(s_eol)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(5)
  ) u_smn (
    .pclk(pclk), .rst(rst), .ce(ce),
    .hcount(n_h), .vcount(n_v), .hsync(n_hs), .vsync(n_vs),
    .hblnk(n_hb), .vblnk(n_vb), .de(n_de), .sof(n_sof), .eol(n_eol)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(n_fc)
`endif
  );

  // Reference model of the small raster, built from the timing description.
  int   m_h, m_v;
  logic m_hs, m_vs, m_hb, m_vb, m_de, m_sof, m_eol;
  logic [15:0] m_fc;

  task automatic model_update(input logic r, input logic c);
    if (r) begin
      m_h = 0; m_v = 0;
      m_hs = 1'b0; m_vs = 1'b0; m_hb = 1'b0; m_vb = 1'b0;
      m_de = 1'b0; m_sof = 1'b0; m_eol = 1'b0; m_fc = 16'd0;
    end else if (c) begin
      if (m_h == 15) begin
        m_h = 0;
        m_v = (m_v == 7) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_hb  = (m_h >= 8);
      m_vb  = (m_v >= 4);
      m_hs  = (m_h >= 10) && (m_h <= 12);
      m_vs  = (m_v >= 5) && (m_v <= 6);
      m_de  = !m_hb && !m_vb;
      m_sof = (m_h == 0) && (m_v == 0);
      m_eol = (m_h == 15);
      if (m_sof) m_fc = m_fc + 16'd1;
    end else begin
      m_sof = 1'b0;
      m_eol = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one pclk edge with the currently driven rst/ce, then score the small instances.
  task automatic step();
    logic r, c;
    r = rst;
    c = ce;
    @(posedge pclk);
    #1;
    model_update(r, c);
    chk("sm_state", {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_de, s_sof, s_eol},
        {5'(m_h), 5'(m_v), m_hs, m_vs, m_hb, m_vb, m_de, m_sof, m_eol});
    chk("smn_state", {n_h, n_v, n_hs, n_vs, n_hb, n_vb, n_de, n_sof, n_eol},
        {5'(m_h), 5'(m_v), ~m_hs, ~m_vs, m_hb, m_vb, m_de, m_sof, m_eol});
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("sm_frame_cnt", s_fc, m_fc);
`endif
  endtask

  initial begin
    int hb_first, hs_first, hs_last, hs_cnt, eol_h, eol_cnt;
    int sof_n, sof_t0, sof_t1, vs_first, vs_last, vb_min, vb_max, wraps;
    int prev_v, sof_run, eol_run, sof_max, eol_max;
    logic done;

    // ---- Reset: held 3 cycles with ce=1, reset must win.
    rst = 1'b1;
    ce  = 1'b1;
    m_h = 0; m_v = 0; m_fc = 16'd0;
    repeat (3) step();
    chk("rst_hcount", d_h, 12'd0);
    chk("rst_vcount", d_v, 12'd0);
    chk("rst_hsync",  d_hs, 1'b0);
    chk("rst_vsync",  d_vs, 1'b0);
    chk("rst_blnk",   {d_hb, d_vb}, 2'b00);
    chk("rst_de",     d_de, 1'b0);
    chk("rst_strobes", {d_sof, d_eol}, 2'b00);
    chk("rst_pol0_syncs", {n_hs, n_vs}, 2'b11);
    rst = 1'b0;
    step();
    chk("first_ce_hcount", d_h, 12'd1);
    chk("first_ce_vcount", d_v, 12'd0);
    chk("first_ce_de",     d_de, 1'b1);
    chk("first_ce_sof",    d_sof, 1'b0);

    // ---- Line on the default timing.
    hb_first = -1; hs_first = -1; hs_last = -1; hs_cnt = 0; eol_h = -1; eol_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 1400 && !done; i++) begin
      step();
      if (d_hb && hb_first < 0) hb_first = int'(d_h);
      if (d_hs) begin
        if (hs_first < 0) hs_first = int'(d_h);
        hs_last = int'(d_h);
        hs_cnt++;
      end
      if (d_eol) begin
        eol_h = int'(d_h);
        eol_cnt++;
      end
      if (d_h == 12'd0) done = 1'b1;
    end
    chk("line_wrap_reached", done, 1'b1);
    chk("line_hblnk_first", hb_first, 1024);
    chk("line_hsync_first", hs_first, 1048);
    chk("line_hsync_last",  hs_last, 1183);
    chk("line_hsync_width", hs_cnt, 136);
    chk("line_eol_hcount",  eol_h, 1343);
    chk("line_eol_count",   eol_cnt, 1);
    chk("line_next_vcount", d_v, 12'd1);
    chk("line_next_flags",  {d_hb, d_de, d_eol, d_hs}, 4'b0100);

    // ---- Two frames on the small raster.
    rst = 1'b1;
    step();
    rst = 1'b0;
    sof_n = 0; sof_t0 = -1; sof_t1 = -1; vs_first = -1; vs_last = -1;
    vb_min = 99; vb_max = -1; wraps = 0; prev_v = 0;
    for (int i = 1; i <= 270; i++) begin
      step();
      if (s_sof) begin
        if (sof_n == 0) sof_t0 = i; else if (sof_n == 1) sof_t1 = i;
        sof_n++;
      end
      if (s_vs) begin
        if (vs_first < 0) vs_first = int'(s_v);
        vs_last = int'(s_v);
      end
      if (s_vb) begin
        if (int'(s_v) < vb_min) vb_min = int'(s_v);
        if (int'(s_v) > vb_max) vb_max = int'(s_v);
      end
      if (prev_v == 7 && s_v == 5'd0) wraps++;
      prev_v = int'(s_v);
    end
    chk("frame_sof_count",  sof_n, 2);
    chk("frame_first_sof",  sof_t0, 128);
    chk("frame_sof_period", sof_t1 - sof_t0, 128);
    chk("frame_vsync_first", vs_first, 5);
    chk("frame_vsync_last",  vs_last, 6);
    chk("frame_vblnk_range", {8'(vb_min), 8'(vb_max)}, {8'd4, 8'd7});
    chk("frame_vwraps", wraps, 2);

    // ---- ce gating 1,0,1,0: period doubles, strobes stay one pclk wide.
    rst = 1'b1;
    step();
    rst = 1'b0;
    sof_n = 0; sof_t0 = -1; sof_t1 = -1;
    sof_run = 0; eol_run = 0; sof_max = 0; eol_max = 0;
    for (int i = 1; i <= 520; i++) begin
      ce = ((i % 2) == 1);
      step();
      if (s_sof) begin
        if (sof_n == 0) sof_t0 = i; else if (sof_n == 1) sof_t1 = i;
        sof_n++;
      end
      sof_run = s_sof ? sof_run + 1 : 0;
      eol_run = s_eol ? eol_run + 1 : 0;
      if (sof_run > sof_max) sof_max = sof_run;
      if (eol_run > eol_max) eol_max = eol_run;
    end
    ce = 1'b1;
    chk("ce_sof_count",  sof_n, 2);
    chk("ce_sof_period", sof_t1 - sof_t0, 256);
    chk("ce_sof_width",  sof_max, 1);
    chk("ce_eol_width",  eol_max, 1);

    // ---- Mid-frame reset with ce low while both syncs are asserted.
    rst = 1'b1;
    step();
    rst = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (s_h == 5'd12 && s_v == 5'd6) done = 1'b1;
    end
    chk("mid_target_reached", done, 1'b1);
    chk("mid_syncs_active", {s_hs, s_vs, n_hs, n_vs}, 4'b1100);
    rst = 1'b1;
    ce  = 1'b0;
    step();
    chk("mid_rst_counters", {s_h, s_v}, 10'd0);
    chk("mid_rst_syncs",    {s_hs, s_vs, n_hs, n_vs}, 4'b0011);
    chk("mid_rst_strobes",  {s_sof, s_eol, s_de}, 3'b000);
    rst = 1'b0;
    ce  = 1'b1;
    step();
    chk("mid_restart", {s_h, s_v}, {5'd1, 5'd0});

`ifdef VGA_TIMING_FRAME_CNT_EN
    // ---- Frame counter wrap from a preloaded 16'hFFFF.
    force u_sm.frame_cnt_q = 16'hFFFF;
    #1;
    release u_sm.frame_cnt_q;
    m_fc = 16'hFFFF;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (s_sof) done = 1'b1;
    end
    chk("fc_sof_reached", done, 1'b1);
    chk("fc_wrap_zero", s_fc, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
